// File: rtl/draw_arb_pkg.sv
// Shared widths and FSM encoding for the VGA draw-port arbiter.
package draw_arb_pkg;

    localparam int X_W    = 8;   // VGA x coordinate width (0..159)
    localparam int Y_W    = 7;   // VGA y coordinate width (0..127)
    localparam int COL_W  = 3;   // RGB colour width
    localparam int WDOG_W = 15;  // watchdog counter width
    localparam int IDX_W  = 3;   // engine index width (up to 8 engines)

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational round-robin picker: searches requests starting at
// last_owner+1 (mod NUM_REQ) and reports the first one found.
module rr_pick
    import draw_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               valid,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    // w_cand[k] is the engine index at search distance k+1 from last_owner
    logic [IDX_W-1:0] w_cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] w_sum;
            assign w_sum = {1'b0, last_owner} + (IDX_W+1)'(gi + 1);
            assign w_cand[gi] = (w_sum >= (IDX_W+1)'(NUM_REQ))
                              ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                              : w_sum[IDX_W-1:0];
        end
    endgenerate

    // Scan from farthest to nearest so the nearest requester overrides
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && (w_cand[k] == IDX_W'(j))) begin
                    valid = 1'b1;
                    idx   = w_cand[k];
                end
            end
        end
        onehot = valid ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing the single VGA pixel-write port among
// several draw engines, with a watchdog that evicts a hung owner.
module draw_arbiter
    import draw_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_CYCLES = 20500
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       done,
    input  logic [NUM_REQ-1:0]       plot_in,
    input  logic [X_W*NUM_REQ-1:0]   x_in,
    input  logic [Y_W*NUM_REQ-1:0]   y_in,
    input  logic [COL_W*NUM_REQ-1:0] col_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [X_W-1:0]           x_out,
    output logic [Y_W-1:0]           y_out,
    output logic [COL_W-1:0]         col_out,
    output logic                     plot_out,
    output logic                     busy,
    output logic                     timeout,
    output logic [IDX_W-1:0]         timeout_id
);

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last_owner;
    logic [WDOG_W-1:0]  r_wdog;
    logic               r_timeout;
    logic [IDX_W-1:0]   r_timeout_id;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [COL_W-1:0]   r_col;
    logic               r_plot;

    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_own_req;
    logic               w_own_done;
    logic               w_own_plot;
    logic [X_W-1:0]     w_own_x;
    logic [Y_W-1:0]     w_own_y;
    logic [COL_W-1:0]   w_own_col;
    logic               w_wdog_exp;
    logic               w_release;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .valid      (w_valid),
        .idx        (w_idx),
        .onehot     (w_onehot)
    );

    // Select the current owner's control and pixel fields
    always_comb begin
        w_own_req  = 1'b0;
        w_own_done = 1'b0;
        w_own_plot = 1'b0;
        w_own_x    = '0;
        w_own_y    = '0;
        w_own_col  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_req  = req[i];
                w_own_done = done[i];
                w_own_plot = plot_in[i];
                w_own_x    = x_in[i*X_W +: X_W];
                w_own_y    = y_in[i*Y_W +: Y_W];
                w_own_col  = col_in[i*COL_W +: COL_W];
            end
        end
    end

    assign w_wdog_exp = (r_wdog == WDOG_W'(MAX_CYCLES - 1));
    assign w_release  = w_own_done || !w_own_req || w_wdog_exp;

    // Arbitration FSM, ownership tracking and watchdog
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_wdog       <= '0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant <= w_onehot;
                        r_owner <= w_idx;
                        r_wdog  <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (r_wdog != {WDOG_W{1'b1}}) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                    if (w_release) begin
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                        r_state      <= ST_RELEASE;
                        // A completing or abandoning engine is never reported as hung
                        if (!w_own_done && w_own_req) begin
                            r_timeout    <= 1'b1;
                            r_timeout_id <= r_owner;
                        end
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered pixel mux: forward the owner's stream, hold position otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x    <= '0;
            r_y    <= '0;
            r_col  <= '0;
            r_plot <= 1'b0;
        end else if (r_state == ST_GRANT) begin
            r_x    <= w_own_x;
            r_y    <= w_own_y;
            r_col  <= w_own_col;
            r_plot <= w_own_plot;
        end else begin
            r_plot <= 1'b0;
        end
    end

    assign grant      = r_grant;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign col_out    = r_col;
    assign plot_out   = r_plot;
    assign busy       = (r_state == ST_GRANT);
    assign timeout    = r_timeout;
    assign timeout_id = r_timeout_id;

endmodule
